// File: rtl/count_monitor.sv
// count_monitor: follows an upstream up-counter, pulses tc on each wrap, counts wraps and flags
// sequence errors. Define COUNT_MONITOR_ERR_CNT_EN to add the err_cnt output.
module count_monitor #(
    parameter int unsigned WIDTH  = 4,
    parameter int unsigned WRAP_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [WIDTH-1:0]  q,
    input  logic              en,
    input  logic              clr_err,
    output logic              tc,
    output logic [WRAP_W-1:0] wraps,
    output logic              err,
    output logic [WIDTH-1:0]  err_val,
`ifdef COUNT_MONITOR_ERR_CNT_EN
    output logic [7:0]        err_cnt,
`endif
    output logic              locked
);

    typedef enum logic [1:0] {StIdle, StTrack, StError} state_t;

    state_t           state;
    logic [WIDTH-1:0] prev;
    logic [WIDTH-1:0] prev_inc;
    logic             wrap_hit;

    assign prev_inc = prev + WIDTH'(1);
    assign wrap_hit = (prev == '1) && (q == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= StIdle;
            prev    <= '0;
            tc      <= 1'b0;
            wraps   <= '0;
            err     <= 1'b0;
            err_val <= '0;
            locked  <= 1'b0;
`ifdef COUNT_MONITOR_ERR_CNT_EN
            err_cnt <= '0;
`endif
        end else begin
            tc <= 1'b0;
            case (state)
                StIdle: begin
                    if (en) begin
                        prev   <= q;
                        state  <= StTrack;
                        locked <= 1'b1;
                    end
                end
                StTrack: begin
                    if (!en) begin
                        state  <= StIdle;
                        locked <= 1'b0;
                    end else if (q == prev_inc) begin
                        prev <= q;
                        if (wrap_hit) begin
                            tc <= 1'b1;
                            if (wraps != '1) begin
                                wraps <= wraps + WRAP_W'(1);
                            end
                        end
                    end else if (q == '0) begin
                        // Upstream resync: accept silently
                        prev <= '0;
                    end else begin
                        err     <= 1'b1;
                        err_val <= q;
                        state   <= StError;
                        locked  <= 1'b0;
`ifdef COUNT_MONITOR_ERR_CNT_EN
                        if (err_cnt != 8'hff) begin
                            err_cnt <= err_cnt + 8'd1;
                        end
`endif
                    end
                end
                StError: begin
                    if (clr_err) begin
                        err     <= 1'b0;
                        err_val <= '0;
                        state   <= StIdle;
                    end
                end
                default: begin
                    state  <= StIdle;
                    locked <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_count_monitor.sv
// Randomised scoreboard bench for count_monitor (WRAP_W=2 so saturation is reachable).
module tb_count_monitor;

    localparam int W    = 4;
    localparam int WW   = 2;
    localparam int M    = 1 << W;
    localparam int WMAX = (1 << WW) - 1;
    localparam int MIdle  = 0;
    localparam int MTrack = 1;
    localparam int MError = 2;

    logic          clk = 1'b0;
    logic          reset, en, clr_err;
    logic [W-1:0]  q;
    logic          tc, err, locked;
    logic [WW-1:0] wraps;
    logic [W-1:0]  err_val;
`ifdef COUNT_MONITOR_ERR_CNT_EN
    logic [7:0]    err_cnt;
`endif

    always #5 clk = ~clk;

    count_monitor #(
        .WIDTH  (W),
        .WRAP_W (WW)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .q       (q),
        .en      (en),
        .clr_err (clr_err),
        .tc      (tc),
        .wraps   (wraps),
        .err     (err),
        .err_val (err_val),
`ifdef COUNT_MONITOR_ERR_CNT_EN
        .err_cnt (err_cnt),
`endif
        .locked  (locked)
    );

    typedef struct {
        int tc;
        int wraps;
        int err;
        int err_val;
        int locked;
        int err_cnt;
    } exp_t;

    exp_t sb[$];
    exp_t mx;
    int   checks = 0;
    int   errors = 0;

    // Reference model state
    int m_mode, m_prev, m_tc, m_wraps, m_err, m_errval, m_errcnt;
    int last_q;

    task automatic cmp(input string name, input integer act, input integer exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    // Drive one sample and push the response expected one clock later
    task automatic step(input bit r, input bit e, input int qq, input bit c);
        exp_t x;
        @(negedge clk);
        reset   = r;
        en      = e;
        q       = qq[W-1:0];
        clr_err = c;
        if (r) begin
            m_mode = MIdle; m_prev = 0; m_tc = 0; m_wraps = 0;
            m_err = 0; m_errval = 0; m_errcnt = 0;
        end else begin
            m_tc = 0;
            if (m_mode == MIdle) begin
                if (e) begin
                    m_prev = qq;
                    m_mode = MTrack;
                end
            end else if (m_mode == MTrack) begin
                if (!e) begin
                    m_mode = MIdle;
                end else if (qq == (m_prev + 1) % M) begin
                    if (qq == 0) begin
                        m_tc = 1;
                        if (m_wraps < WMAX) m_wraps++;
                    end
                    m_prev = qq;
                end else if (qq == 0) begin
                    m_prev = 0;
                end else begin
                    m_err = 1;
                    m_errval = qq;
                    m_mode = MError;
                    if (m_errcnt < 255) m_errcnt++;
                end
            end else if (c) begin
                m_err = 0;
                m_errval = 0;
                m_mode = MIdle;
            end
        end
        x.tc = m_tc;
        x.wraps = m_wraps;
        x.err = m_err;
        x.err_val = m_errval;
        x.locked = (m_mode == MTrack) ? 1 : 0;
        x.err_cnt = m_errcnt;
        sb.push_back(x);
        last_q = qq;
    endtask

    always begin
        @(posedge clk);
        #1;
        if (sb.size() > 0) begin
            mx = sb.pop_front();
            cmp("tc", tc, mx.tc);
            cmp("wraps", wraps, mx.wraps);
            cmp("err", err, mx.err);
            cmp("err_val", err_val, mx.err_val);
            cmp("locked", locked, mx.locked);
`ifdef COUNT_MONITOR_ERR_CNT_EN
            cmp("err_cnt", err_cnt, mx.err_cnt);
`endif
        end
    end

    initial begin
        int qq;
        int sel;
        reset = 1'b1; en = 1'b0; q = '0; clr_err = 1'b0;
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        // Full count 0..15,0 then four more wraps to reach saturation
        for (int i = 0; i < M; i++) step(0, 1, i, 0);
        step(0, 1, 0, 0);
        for (int w = 0; w < 4; w++) begin
            for (int i = 1; i < M; i++) step(0, 1, i, 0);
            step(0, 1, 0, 0);
        end
        // Sequence error 5,6,9 then clear
        for (int i = 1; i <= 6; i++) step(0, 1, i, 0);
        step(0, 1, 9, 0);
        step(0, 1, 9, 0);
        step(0, 1, 9, 1);
        step(0, 0, 0, 0);
        // Upstream reset mid-count
        step(0, 1, 5, 0);
        step(0, 1, 6, 0);
        step(0, 1, 7, 0);
        step(0, 1, 0, 0);
        step(0, 1, 1, 0);
        // clr_err while tracking with a mismatch: mismatch wins
        step(0, 1, 7, 1);
        step(0, 0, 0, 1);
        // Reset coincident with a 15->0 sample
        step(0, 1, 14, 0);
        step(0, 1, 15, 0);
        step(1, 1, 0, 0);
        step(0, 0, 0, 0);
        // Three error/clear cycles, then reset
        for (int k = 0; k < 3; k++) begin
            step(0, 1, 3, 0);
            step(0, 1, 8, 0);
            step(0, 0, 0, 1);
        end
        step(0, 0, 0, 0);
        step(1, 0, 0, 0);
        // Randomised traffic, mostly well-formed counting
        for (int n = 0; n < 3000; n++) begin
            sel = $urandom_range(0, 19);
            if (sel == 0) qq = $urandom_range(0, M - 1);
            else if (sel == 1) qq = 0;
            else qq = (last_q + 1) % M;
            step($urandom_range(0, 99) == 0, $urandom_range(0, 9) != 0, qq,
                 $urandom_range(0, 7) == 0);
        end
        step(0, 0, 0, 0);
        repeat (3) @(negedge clk);
        cmp("drain", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
